rom_dl_sequencer: RTL and testbench

Sequences the HPS ROM download stream into the M62 core's storage. It captures each `ioctl` byte and decodes its region. It then issues toggle-handshake write requests to the two SDRAM ports, strobes the sound-ROM DPRAM and PROM loaders, and stalls the HPS until every target has accepted the byte. It also owns the `rom_loaded` flag and the post-download / user reset stretch that feeds `target_top`.

---
 rtl/m62_dl_pkg.sv | 37 +++
 rtl/toggle_req_port.sv | 34 +++
 rtl/rom_dl_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/m62_dl_pkg.sv
// Shared definitions for the M62 ROM download path: region map, region and FSM enums.
// Pure declarations; no latency or backpressure of its own.
// Address decode helper used at byte capture time.
package m62_dl_pkg;

    localparam logic [24:0] CPU1_BASE = 25'h000_0000;
    localparam logic [24:0] SND_BASE  = 25'h002_0000;
    localparam logic [24:0] GFX_BASE  = 25'h003_0000;
    localparam logic [24:0] PROM_BASE = 25'h00A_0000;
    localparam logic [24:0] PROM_END  = 25'h00A_091F;

    typedef enum logic [2:0] {
        RGN_CPU1,
        RGN_SND,
        RGN_GFX,
        RGN_PROM,
        RGN_NONE
    } dl_region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } dl_state_e;

    function automatic dl_region_e dl_decode(input logic [24:0] addr);
        dl_region_e rgn;
        if (addr < SND_BASE)       rgn = RGN_CPU1;
        else if (addr < GFX_BASE)  rgn = RGN_SND;
        else if (addr < PROM_BASE) rgn = RGN_GFX;
        else if (addr <= PROM_END) rgn = RGN_PROM;
        else                       rgn = RGN_NONE;
        return rgn;
    endfunction

endpackage

// File: rtl/toggle_req_port.sv
// Toggle-handshake request tracker for one SDRAM write port.
// Latency: req toggles on the edge after i_issue; done is combinational on ack.
// Backpressure: o_done stays low until ack matches req, or the request is abandoned.
module toggle_req_port (
    input  logic i_clk_sys,
    input  logic i_reset_n,
    input  logic i_issue,
    input  logic i_abandon,
    input  logic i_ack,
    output logic o_req,
    output logic o_done
);

    logic r_req;
    logic r_bias;

    // An abandoned request folds the missing ack into r_bias, so the next
    // single ack toggle from the SDRAM completes the next request.
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req  <= 1'b0;
            r_bias <= 1'b0;
        end else begin
            if (i_issue)
                r_req <= ~r_req;
            if (i_abandon)
                r_bias <= i_ack ^ r_req;
        end
    end

    assign o_req  = r_req;
    assign o_done = ((i_ack ^ r_bias) == r_req);

endmodule

// File: rtl/rom_dl_sequencer.sv
// Sequences HPS ioctl download bytes into SDRAM ports, sound DPRAM and PROM loaders.
// Latency: wait 1 cycle after sampled wr rise, req/strobe at 2, release 1 cycle after last ack.
// Backpressure: ioctl_wait held until every target accepted the byte or the ack timed out.
import m62_dl_pkg::*;

module rom_dl_sequencer #(
    parameter logic [15:0] RST_CYCLES  = 16'hFFFF,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        i_clk_sys,
    input  logic        i_reset_n,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_ioctl_wait,
    input  logic        i_reset_req,
    output logic        o_port1_req,
    input  logic        i_port1_ack,
    output logic [22:0] o_port1_a,
    output logic [1:0]  o_port1_ds,
    output logic [15:0] o_port1_d,
    output logic        o_port2_req,
    input  logic        i_port2_ack,
    output logic [22:0] o_port2_a,
    output logic [1:0]  o_port2_ds,
    output logic [15:0] o_port2_d,
    output logic        o_snd_we,
    output logic [15:0] o_snd_addr,
    output logic [7:0]  o_snd_d,
    output logic        o_prom_we,
    output logic [11:0] o_prom_addr,
    output logic [7:0]  o_prom_d,
    output logic        o_rom_loaded,
    output logic        o_core_reset,
    output logic        o_ack_err
);

    dl_state_e  r_state, w_next;
    dl_region_e r_region;

    logic        r_wr_s, r_wr_d, r_dl_s, r_idx0_s;
    logic [24:0] r_addr_s;
    logic [7:0]  r_dout_s;
    logic [23:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_wait, r_snd_we, r_prom_we, r_ack_err, r_rom_loaded, r_end_pend;
    logic [7:0]  r_to_cnt;
    logic [15:0] r_rst_cnt;
    logic        r_core_reset;

    logic w_wr_rise, w_dl_fall, w_capture, w_issue, w_abandon, w_wait_clr;
    logic w_sel_p1, w_sel_p2, w_sel_snd, w_sel_prom;
    logic w_p1_done, w_p2_done, w_all_done, w_reload;
    logic [23:0] w_p1_off, w_p2_off;
    logic [11:0] w_prom_off;

    // The stream is registered once so the edge detect and the captured
    // address/data always come from the same sample.
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_s   <= 1'b0;
            r_wr_d   <= 1'b0;
            r_dl_s   <= 1'b0;
            r_idx0_s <= 1'b0;
            r_addr_s <= '0;
            r_dout_s <= '0;
        end else begin
            r_wr_s   <= i_ioctl_wr;
            r_wr_d   <= r_wr_s;
            r_dl_s   <= i_ioctl_download;
            r_idx0_s <= (i_ioctl_index == 8'd0);
            r_addr_s <= i_ioctl_addr;
            r_dout_s <= i_ioctl_dout;
        end
    end

    assign w_wr_rise = r_wr_s & ~r_wr_d & r_dl_s & r_idx0_s;
    assign w_dl_fall = r_dl_s & ~i_ioctl_download & (i_ioctl_index == 8'd0);

    assign w_sel_p1   = (r_region == RGN_CPU1) || (r_region == RGN_GFX);
    assign w_sel_p2   = (r_region == RGN_GFX);
    assign w_sel_snd  = (r_region == RGN_SND);
    assign w_sel_prom = (r_region == RGN_PROM);
    assign w_all_done = (~w_sel_p1 | w_p1_done) & (~w_sel_p2 | w_p2_done);

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_issue    = 1'b0;
        w_abandon  = 1'b0;
        w_wait_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_rise) begin
                    w_capture = 1'b1;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                w_next  = (w_sel_p1 || w_sel_p2) ? ST_WAIT_ACK : ST_DONE;
            end
            ST_WAIT_ACK: begin
                if (w_all_done) begin
                    w_next = ST_DONE;
                end else if (r_to_cnt == ACK_TIMEOUT) begin
                    w_abandon = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_wait_clr = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr    <= '0;
            r_dout    <= '0;
            r_region  <= RGN_NONE;
            r_wait    <= 1'b0;
            r_snd_we  <= 1'b0;
            r_prom_we <= 1'b0;
            r_to_cnt  <= '0;
            r_ack_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr   <= r_addr_s[23:0];
                r_dout   <= r_dout_s;
                r_region <= dl_decode(r_addr_s);
            end
            if (w_capture)       r_wait <= 1'b1;
            else if (w_wait_clr) r_wait <= 1'b0;
            r_snd_we  <= w_issue & w_sel_snd;
            r_prom_we <= w_issue & w_sel_prom;
            // Counts cycles spent in WAIT_ACK, including the current one.
            if (w_issue)
                r_to_cnt <= 8'd1;
            else if (r_state == ST_WAIT_ACK && w_next == ST_WAIT_ACK)
                r_to_cnt <= r_to_cnt + 8'd1;
            if (w_abandon)
                r_ack_err <= 1'b1;
        end
    end

    // A download ending mid-byte is remembered until the FSM is back in IDLE.
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rom_loaded <= 1'b0;
            r_end_pend   <= 1'b0;
        end else if ((w_dl_fall || r_end_pend) && r_state == ST_IDLE && !w_wr_rise) begin
            r_rom_loaded <= 1'b1;
            r_end_pend   <= 1'b0;
        end else if (w_dl_fall) begin
            r_end_pend   <= 1'b1;
        end
    end

    assign w_reload = i_reset_req | i_ioctl_download | ~r_rom_loaded;

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_cnt    <= RST_CYCLES;
            r_core_reset <= 1'b1;
        end else begin
            if (w_reload)
                r_rst_cnt <= RST_CYCLES;
            else if (r_rst_cnt != 16'd0)
                r_rst_cnt <= r_rst_cnt - 16'd1;
            r_core_reset <= (r_rst_cnt != 16'd0);
        end
    end

    toggle_req_port u_port1 (
        .i_clk_sys (i_clk_sys),
        .i_reset_n (i_reset_n),
        .i_issue   (w_issue & w_sel_p1),
        .i_abandon (w_abandon & w_sel_p1),
        .i_ack     (i_port1_ack),
        .o_req     (o_port1_req),
        .o_done    (w_p1_done)
    );

    toggle_req_port u_port2 (
        .i_clk_sys (i_clk_sys),
        .i_reset_n (i_reset_n),
        .i_issue   (w_issue & w_sel_p2),
        .i_abandon (w_abandon & w_sel_p2),
        .i_ack     (i_port2_ack),
        .o_req     (o_port2_req),
        .o_done    (w_p2_done)
    );

    assign w_p1_off   = r_addr - CPU1_BASE[23:0];
    assign w_p2_off   = r_addr - GFX_BASE[23:0];
    assign w_prom_off = r_addr[11:0] - PROM_BASE[11:0];

    assign o_port1_a   = w_p1_off[23:1];
    assign o_port1_ds  = {w_p1_off[0], ~w_p1_off[0]};
    assign o_port1_d   = {r_dout, r_dout};
    assign o_port2_a   = w_p2_off[23:1];
    assign o_port2_ds  = {w_p2_off[0], ~w_p2_off[0]};
    assign o_port2_d   = {r_dout, r_dout};
    assign o_snd_we    = r_snd_we;
    assign o_snd_addr  = r_addr[15:0];
    assign o_snd_d     = r_dout;
    assign o_prom_we   = r_prom_we;
    assign o_prom_addr = w_prom_off;
    assign o_prom_d    = r_dout;
    assign o_ioctl_wait = r_wait;
    assign o_rom_loaded = r_rom_loaded;
    assign o_core_reset = r_core_reset;
    assign o_ack_err    = r_ack_err;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: region decode, handshakes, timeout and reset stretch.
module tb_rom_dl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ioctl_download, ioctl_wr, reset_req;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait;
    logic        port1_req, port1_ack, port2_req, port2_ack;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        snd_we, prom_we;
    logic [15:0] snd_addr;
    logic [7:0]  snd_d, prom_d;
    logic [11:0] prom_addr;
    logic        rom_loaded, core_reset, ack_err;

    int checks = 0;
    int errors = 0;

    rom_dl_sequencer #(.RST_CYCLES(16'd16), .ACK_TIMEOUT(8'd255)) dut (
        .i_clk_sys(clk), .i_reset_n(rst_n),
        .i_ioctl_download(ioctl_download), .i_ioctl_index(ioctl_index),
        .i_ioctl_wr(ioctl_wr), .i_ioctl_addr(ioctl_addr), .i_ioctl_dout(ioctl_dout),
        .o_ioctl_wait(ioctl_wait), .i_reset_req(reset_req),
        .o_port1_req(port1_req), .i_port1_ack(port1_ack), .o_port1_a(port1_a),
        .o_port1_ds(port1_ds), .o_port1_d(port1_d),
        .o_port2_req(port2_req), .i_port2_ack(port2_ack), .o_port2_a(port2_a),
        .o_port2_ds(port2_ds), .o_port2_d(port2_d),
        .o_snd_we(snd_we), .o_snd_addr(snd_addr), .o_snd_d(snd_d),
        .o_prom_we(prom_we), .o_prom_addr(prom_addr), .o_prom_d(prom_d),
        .o_rom_loaded(rom_loaded), .o_core_reset(core_reset), .o_ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle ioctl_wr pulse; returns just after the edge that samples it.
    task automatic start_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ioctl_download = 0; ioctl_wr = 0; reset_req = 0;
        ioctl_index = 0; ioctl_dout = 0; ioctl_addr = 0;
        port1_ack = 0; port2_ack = 0;
        #12;
        checks++; if ({ioctl_wait, port1_req, port2_req, snd_we, prom_we} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b exp 00000", {ioctl_wait, port1_req, port2_req, snd_we, prom_we}); end
        checks++; if ({rom_loaded, ack_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {rom_loaded, ack_err}); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b exp 1", core_reset); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ioctl_download = 1'b1;
        tick();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_idle_wait: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_port1();
        start_write(8'd0, 25'h00005, 8'h12);
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL p1_wait_early: got %b exp 0", ioctl_wait); end
        tick();
        checks++; if ({ioctl_wait, port1_req} !== 2'b10) begin errors++; $display("FAIL p1_wait_rise: got %b exp 10", {ioctl_wait, port1_req}); end
        tick();
        checks++; if ({port1_req, port2_req} !== 2'b10) begin errors++; $display("FAIL p1_req: got %b exp 10", {port1_req, port2_req}); end
        checks++; if (port1_a !== 23'h000002) begin errors++; $display("FAIL p1_addr: got %h exp 000002", port1_a); end
        checks++; if ({port1_ds, port1_d} !== {2'b10, 16'h1212}) begin errors++; $display("FAIL p1_ds_d: got %b %h exp 10 1212", port1_ds, port1_d); end
        tick(); tick();
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL p1_wait_hold: got %b exp 1", ioctl_wait); end
        port1_ack = 1'b1;
        tick();
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL p1_wait_at_ack: got %b exp 1", ioctl_wait); end
        tick();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL p1_release: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_bad_index();
        start_write(8'd1, 25'h00005, 8'h99);
        tick(); tick();
        checks++; if ({ioctl_wait, port1_req, snd_we, prom_we} !== 4'b0100) begin errors++; $display("FAIL bad_index: got %b exp 0100", {ioctl_wait, port1_req, snd_we, prom_we}); end
    endtask

    task automatic test_gfx();
        start_write(8'd0, 25'h30010, 8'h5A);
        tick(); tick();
        checks++; if ({port1_req, port2_req} !== 2'b01) begin errors++; $display("FAIL gfx_reqs: got %b exp 01", {port1_req, port2_req}); end
        checks++; if (port1_a !== 23'h018008) begin errors++; $display("FAIL gfx_p1_addr: got %h exp 018008", port1_a); end
        checks++; if (port2_a !== 23'h000008) begin errors++; $display("FAIL gfx_p2_addr: got %h exp 000008", port2_a); end
        checks++; if ({port2_ds, port2_d} !== {2'b01, 16'h5A5A}) begin errors++; $display("FAIL gfx_p2_ds_d: got %b %h exp 01 5a5a", port2_ds, port2_d); end
        port1_ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL gfx_wait_p2: got %b exp 1", ioctl_wait); end
        port2_ack = 1'b1;
        tick();
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL gfx_wait_at_ack: got %b exp 1", ioctl_wait); end
        tick();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL gfx_release: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_snd();
        start_write(8'd0, 25'h2FFFF, 8'hAB);
        tick(); tick();
        checks++; if ({snd_we, snd_addr, snd_d} !== {1'b1, 16'hFFFF, 8'hAB}) begin errors++; $display("FAIL snd_strobe: got %b %h %h exp 1 ffff ab", snd_we, snd_addr, snd_d); end
        checks++; if ({port1_req, port2_req} !== 2'b01) begin errors++; $display("FAIL snd_no_req: got %b exp 01", {port1_req, port2_req}); end
        tick();
        checks++; if ({snd_we, ioctl_wait} !== 2'b00) begin errors++; $display("FAIL snd_pulse_release: got %b exp 00", {snd_we, ioctl_wait}); end
    endtask

    task automatic test_prom();
        start_write(8'd0, 25'hA091F, 8'h77);
        tick(); tick();
        checks++; if ({prom_we, prom_addr, prom_d} !== {1'b1, 12'h91F, 8'h77}) begin errors++; $display("FAIL prom_strobe: got %b %h %h exp 1 91f 77", prom_we, prom_addr, prom_d); end
        tick();
        checks++; if ({prom_we, ioctl_wait} !== 2'b00) begin errors++; $display("FAIL prom_release: got %b exp 00", {prom_we, ioctl_wait}); end
        start_write(8'd0, 25'hA0920, 8'h78);
        tick();
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL drop_wait: got %b exp 1", ioctl_wait); end
        tick();
        checks++; if ({prom_we, snd_we, port1_req, port2_req} !== 4'b0001) begin errors++; $display("FAIL drop_no_strobe: got %b exp 0001", {prom_we, snd_we, port1_req, port2_req}); end
        tick();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL drop_release: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_timeout();
        int n;
        start_write(8'd0, 25'h00100, 8'h01);
        tick(); tick();
        checks++; if (port1_req !== 1'b1) begin errors++; $display("FAIL to_req: got %b exp 1", port1_req); end
        n = 0;
        for (int i = 0; i < 300 && ack_err !== 1'b1; i++) begin
            tick();
            n++;
        end
        checks++; if (n !== 255) begin errors++; $display("FAIL to_cycles: got %0d exp 255", n); end
        checks++; if ({ack_err, ioctl_wait} !== 2'b11) begin errors++; $display("FAIL to_err_set: got %b exp 11", {ack_err, ioctl_wait}); end
        tick();
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL to_release: got %b exp 0", ioctl_wait); end
        start_write(8'd0, 25'h00002, 8'h33);
        tick(); tick();
        checks++; if ({port1_req, port1_a, port1_ds} !== {1'b0, 23'h000001, 2'b01}) begin errors++; $display("FAIL to_next_req: got %b %h %b exp 0 000001 01", port1_req, port1_a, port1_ds); end
        port1_ack = 1'b1;
        tick(); tick();
        checks++; if ({ioctl_wait, ack_err} !== 2'b01) begin errors++; $display("FAIL to_next_done: got %b exp 01", {ioctl_wait, ack_err}); end
    endtask

    task automatic test_download_end();
        checks++; if ({rom_loaded, core_reset} !== 2'b01) begin errors++; $display("FAIL dl_pre: got %b exp 01", {rom_loaded, core_reset}); end
        ioctl_download = 1'b0;
        tick();
        checks++; if ({rom_loaded, core_reset} !== 2'b11) begin errors++; $display("FAIL dl_loaded: got %b exp 11", {rom_loaded, core_reset}); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL dl_stretch_hold: got %b exp 1", core_reset); end
        tick();
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL dl_stretch_end: got %b exp 0", core_reset); end
        reset_req = 1'b1;
        tick(); tick();
        checks++; if ({core_reset, rom_loaded} !== 2'b11) begin errors++; $display("FAIL user_reset: got %b exp 11", {core_reset, rom_loaded}); end
        reset_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_port1();
        test_bad_index();
        test_gfx();
        test_snd();
        test_prom();
        test_timeout();
        test_download_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
